mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port; a read holds its grant until mem_rd_valid.
// Define MEM_ARB_FIXED_PRIO_EN for fixed master-0 priority; otherwise contention is round-robin.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_ren,
    input  logic            m0_wen,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    input  logic            m1_ren,
    input  logic            m1_wen,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_rd_valid,
    output logic            busy
);

    localparam int MW = DW / 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            owner_r;
    logic            owner_s;
    logic            last_r;
    logic            last_s;
    logic [AW-1:0]   rd_addr_r;
    logic [AW-1:0]   rd_addr_s;

    logic            req0_s;
    logic            req1_s;
    logic            winner_s;
    logic            win_wr_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_wdata_s;
    logic [MW-1:0]   win_wmask_s;

    // Request decode, winner selection and winner operand mux
    always_comb begin
        req0_s   = m0_ren | m0_wen;
        req1_s   = m1_ren | m1_wen;
        winner_s = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (req0_s) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
`else
        // On a tie the master that was not granted last goes first
        if (req0_s && req1_s) begin
            winner_s = ~last_r;
        end else if (req0_s) begin
            winner_s = 1'b0;
        end else begin
            winner_s = 1'b1;
        end
`endif
        // Write strobe dominates: a dual-strobe request is a write
        if (winner_s) begin
            win_wr_s    = m1_wen;
            win_addr_s  = m1_addr;
            win_wdata_s = m1_wdata;
            win_wmask_s = m1_wmask;
        end else begin
            win_wr_s    = m0_wen;
            win_addr_s  = m0_addr;
            win_wdata_s = m0_wdata;
            win_wmask_s = m0_wmask;
        end
    end

    // Next-state logic and memory/ack outputs
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        last_s    = last_r;
        rd_addr_s = rd_addr_r;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_wmask = {MW{1'b1}};
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_s || req1_s) begin
                    mem_addr  = win_addr_s;
                    mem_wdata = win_wdata_s;
                    mem_wmask = win_wmask_s;
                    last_s    = winner_s;
                    if (win_wr_s) begin
                        mem_wen = 1'b1;
                        m0_ack  = ~winner_s;
                        m1_ack  = winner_s;
                    end else begin
                        mem_ren   = 1'b1;
                        owner_s   = winner_s;
                        rd_addr_s = win_addr_s;
                        state_s   = RD_WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                mem_addr = rd_addr_r;
                // Completion goes to the owner even if it has since dropped its request
                if (mem_rd_valid) begin
                    m0_ack  = ~owner_r;
                    m1_ack  = owner_r;
                    state_s = IDLE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            rd_addr_r <= {AW{1'b0}};
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            rd_addr_r <= rd_addr_s;
        end
    end

    assign busy     = (state_r == RD_WAIT);
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

endmodule
